// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// load-mask encodings and store-data / alignment helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] LM_B = 4'b0001;
  localparam logic [3:0] LM_H = 4'b0011;
  localparam logic [3:0] LM_W = 4'b1111;
  localparam int LM_ZEXT = 4;

  localparam int WAIT_CYCLES_MAX = 7;

  // Store data arrives unshifted, so spread it across every lane it could target.
  function automatic logic [31:0] store_replicate(input logic [31:0] wdata,
                                                  input logic [3:0]  size_mask);
    logic [31:0] rep;
    case (size_mask)
      LM_B:    rep = {4{wdata[7:0]}};
      LM_H:    rep = {2{wdata[15:0]}};
      LM_W:    rep = wdata;
      default: rep = wdata;
    endcase
    return rep;
  endfunction

  function automatic logic is_misaligned(input logic [3:0] size_mask,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size_mask)
      LM_H:    mis = addr_lo[0];
      LM_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load-data alignment and extension: picks the addressed byte/half out of a
// RAM word and sign- or zero-extends it according to the load mask.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  logic [4:0]  l_mask,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        fill_s;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_s = rd_word[7:0];
      2'd1:    byte_s = rd_word[15:8];
      2'd2:    byte_s = rd_word[23:16];
      2'd3:    byte_s = rd_word[31:24];
      default: byte_s = rd_word[7:0];
    endcase

    // addr_lo[0] is ignored for halves: misaligned halves snap to the boundary.
    if (addr_lo[1]) begin
      half_s = rd_word[31:16];
    end else begin
      half_s = rd_word[15:0];
    end

    case (l_mask[3:0])
      LM_B: begin
        fill_s   = ~l_mask[LM_ZEXT] & byte_s[7];
        ext_data = {{24{fill_s}}, byte_s};
      end
      LM_H: begin
        fill_s   = ~l_mask[LM_ZEXT] & half_s[15];
        ext_data = {{16{fill_s}}, half_s};
      end
      LM_W: begin
        fill_s   = 1'b0;
        ext_data = rd_word;
      end
      default: begin
        fill_s   = 1'b0;
        ext_data = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with configurable latency.
// Define DMEM_ALIGN_CHECK_EN to report misaligned half/word accesses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_flush,
  input  logic        req_re,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_l_mask,
  input  logic [3:0]  req_byte_we,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_LIM = (WAIT_CYCLES > WAIT_CYCLES_MAX) ?
                                    3'(WAIT_CYCLES_MAX) : 3'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lo_q, lo_d;
  logic [4:0]    lmask_q, lmask_d;
  logic          load_q, load_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rerr_q, rerr_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept_s;
  logic          req_oor_s;
  logic          req_mis_s;
  logic          req_err_s;
  logic          wr_en_s;
  logic [31:0]   wdata_rep_s;
  logic [AW-1:0] rd_idx_s;
  logic [1:0]    rd_lo_s;
  logic [4:0]    rd_lmask_s;
  logic          rd_load_s;
  logic          rd_err_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   ext_s;
  logic          kill_s;

  // Request acceptance and error classification.
  always_comb begin
    accept_s  = (req_re | req_we) & (state_q == ST_IDLE) & ~pipe_flush;
    req_oor_s = (req_addr[31:2] >= 30'(DEPTH_WORDS));
`ifdef DMEM_ALIGN_CHECK_EN
    req_mis_s = is_misaligned(req_l_mask[3:0], req_addr[1:0]);
`else
    req_mis_s = 1'b0;
`endif
    req_err_s   = (req_re & req_we) | req_oor_s | req_mis_s;
    wr_en_s     = accept_s & req_we & ~req_err_s;
    wdata_rep_s = store_replicate(req_wdata, req_l_mask[3:0]);
  end

  // Stores commit on the accept edge; lanes come pre-shifted from the core.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (req_byte_we[b]) begin
          mem[req_addr[AW+1:2]][8*b +: 8] <= wdata_rep_s[8*b +: 8];
        end
      end
    end
  end

  // Live request fields in IDLE (zero-wait path), captured fields otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      rd_idx_s   = req_addr[AW+1:2];
      rd_lo_s    = req_addr[1:0];
      rd_lmask_s = req_l_mask;
      rd_load_s  = req_re;
      rd_err_s   = req_err_s;
    end else begin
      rd_idx_s   = idx_q;
      rd_lo_s    = lo_q;
      rd_lmask_s = lmask_q;
      rd_load_s  = load_q;
      rd_err_s   = err_q;
    end
  end

  assign rd_word_s = mem[rd_idx_s];

  dmem_load_ext u_load_ext (
    .rd_word  (rd_word_s),
    .addr_lo  (rd_lo_s),
    .l_mask   (rd_lmask_s),
    .ext_data (ext_s)
  );

  // Next-state logic and registered response staging.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    lmask_d = lmask_q;
    load_d  = load_q;
    err_d   = err_q;
    kill_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          idx_d   = req_addr[AW+1:2];
          lo_d    = req_addr[1:0];
          lmask_d = req_l_mask;
          load_d  = req_re;
          err_d   = req_err_s;
          if (WAIT_LIM == 3'd0) begin
            state_d = ST_RESP;
            cnt_d   = 3'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 3'd1;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      end
      ST_WAIT: begin
        if (pipe_flush & load_q) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q >= WAIT_LIM) begin
          state_d = ST_RESP;
          cnt_d   = 3'd0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      ST_RESP: begin
        // A store is already in memory, so only a load can be withdrawn here.
        kill_s  = pipe_flush & load_q;
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
    if ((state_d == ST_RESP) && rd_load_s && !rd_err_s) begin
      rdata_d = ext_s;
    end else begin
      rdata_d = 32'h0000_0000;
    end
    if (state_d == ST_RESP) begin
      rerr_d = rd_err_s;
    end else begin
      rerr_d = 1'b0;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      lo_q    <= 2'd0;
      lmask_q <= 5'd0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= 32'h0000_0000;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      lmask_q <= lmask_d;
      load_q  <= load_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q & ~kill_s;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096: RAM depth in 32-bit words; power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra latency cycles, range 0..7.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port pipe_flush, input, 1: cancels a pending load.
REQ-006 SHALL have port req_re, input, 1: load request.
REQ-007 SHALL have port req_we, input, 1: store request.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_l_mask, input, 5: [3:0] byte mask 0001/0011/1111; [4]=1 zero-extend, 0 sign-extend.
REQ-010 SHALL have port req_byte_we, input, 4: lane write enables, already shifted to address lane.
REQ-011 SHALL have port req_wdata, input, 32: unshifted store data (rs2).
REQ-012 SHALL have port req_ready, output, 1: high only in IDLE.
REQ-013 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port rsp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1: qualified by rsp_valid.

Function
REQ-016 SHALL accept a request when (req_re|req_we) & req_ready, registering address, masks and data.
REQ-017 SHALL use FSM IDLE->WAIT (WAIT_CYCLES>0) or IDLE->RESP (WAIT_CYCLES=0); WAIT->RESP when the wait counter reaches WAIT_CYCLES; RESP->IDLE unconditionally.
REQ-018 SHALL pulse rsp_valid in RESP; accept-to-rsp_valid latency is WAIT_CYCLES+1 cycles.
REQ-019 SHALL ignore requests while not IDLE; no queuing.
REQ-020 SHALL commit stores in the accept cycle by writing lanes with req_byte_we=1 as req_wdata replicated per mask (byte x4, half x2, word x1).
REQ-021 SHALL read loads from word addr[31:2]; select the byte via addr[1:0] or the half via addr[1]; extend per req_l_mask[4].
REQ-022 SHALL flag rsp_err with no write when req_re and req_we are both high; rsp_valid still pulses.
REQ-023 SHALL flag rsp_err with no write and rdata 0 when the word index >= DEPTH_WORDS.
REQ-024 SHALL, on pipe_flush in WAIT or RESP of a load, return to IDLE with no rsp_valid that or any later cycle.
REQ-025 SHALL complete a store normally when pipe_flush arrives after acceptance, because the write is already committed.
REQ-026 SHALL give pipe_flush in the accept cycle priority: request dropped, no write.

Reset
REQ-027 SHALL, on rst, set FSM to IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 SHALL abandon any in-flight transaction on rst without a response; RAM contents are not cleared.

Configuration
REQ-029 SHALL, with DMEM_ALIGN_CHECK_EN defined, flag rsp_err with no write for halfword at addr[0]=1 or word at addr[1:0]!=0.
REQ-030 SHALL, without DMEM_ALIGN_CHECK_EN, force misaligned accesses to the natural boundary (clear low address bits) and complete them without error.

Structure
REQ-031 SHALL keep in shared package dmem_pkg: FSM state enum, l_mask encodings (LM_B, LM_H, LM_W, LM_ZEXT bit index), WAIT_CYCLES maximum.
REQ-032 SHALL place load alignment and extension in one combinational sub-module dmem_load_ext.

Verification
REQ-033 SHALL cover: SW 0xDEADBEEF @0x10, then LW @0x10 with WAIT_CYCLES=1 -> rsp_valid 2 cycles after accept, rdata 0xDEADBEEF, err 0.
REQ-034 SHALL cover: LB @0x13 and LBU @0x13 after REQ-033 -> 0xFFFFFFDE, 0x000000DE.
REQ-035 SHALL cover: SH 0x1234 @0x12, byte_we 1100, then LW @0x10 -> 0x1234BEEF.
REQ-036 SHALL cover: LW @0x11 -> err=1, rdata 0 with DMEM_ALIGN_CHECK_EN; rdata of @0x10 without it.
REQ-037 SHALL cover: LW accepted, pipe_flush next cycle -> no rsp_valid, req_ready=1 the following cycle.
REQ-038 SHALL cover: re=we=1 @0x20, and LW @ DEPTH_WORDS*4 -> err=1 in both, memory @0x20 unchanged.
